// File: rtl/my_acc_16.sv
// 16-bit accumulator: {op, D} command in, ACC +/- D (mod 2^WIDTH) out with carry/ovf/zero; MY_ACC_SATURATE_EN clamps on signed overflow.
// Latency: command accepted at edge N, result valid after edge N+1; three cycles per command minimum.
// Backpressure: in_ready only while idle; result held in DONE until out_ready.
module my_acc_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ACC,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] acc_q, acc_nxt;
  logic             carry_q, carry_nxt;
  logic             ovf_q, ovf_nxt;

  logic [WIDTH-1:0] a, b, r;
  logic [WIDTH:0]   sum_ext;
  logic             sub, ovf_now;

  // Extended-width add/sub: bit WIDTH is carry-out for ADD and borrow (A < B) for SUB.
  always_comb begin
    a       = acc_q;
    b       = d_q;
    sub     = (op_q == OP_SUB);
    sum_ext = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    r       = sum_ext[WIDTH-1:0];
    if (sub) begin
      ovf_now = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      ovf_now = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_comb begin
    acc_nxt   = acc_q;
    carry_nxt = 1'b0;
    ovf_nxt   = 1'b0;
    case (op_q)
      OP_LOAD: acc_nxt = d_q;
      OP_ADD, OP_SUB: begin
        carry_nxt = sum_ext[WIDTH];
        ovf_nxt   = ovf_q | ovf_now;
`ifdef MY_ACC_SATURATE_EN
        if (ovf_now) begin
          acc_nxt = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          acc_nxt = r;
        end
`else
        acc_nxt = r;
`endif
      end
      OP_CLEAR: acc_nxt = '0;
      default:  acc_nxt = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      d_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        op_q <= op;
        d_q  <= D;
      end
      if (state_q == EXEC) begin
        acc_q   <= acc_nxt;
        carry_q <= carry_nxt;
        ovf_q   <= ovf_nxt;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ACC       = acc_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = (acc_q == '0);

endmodule

// File: tb/tb_my_acc_16.sv
// Bench for my_acc_16: transaction-level reference model checked every cycle, directed literal cases, then random traffic.
// Literal expectations follow MY_ACC_SATURATE_EN when it is defined.
module tb_my_acc_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [15:0] d = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] acc;
  logic        carry, ovf, zero;

  int tests = 0;
  int fails = 0;

  // Model state: one outstanding command; stage 1 = executing, stage 2 = result presented.
  bit          m_busy = 0;
  int          m_stage = 0;
  logic [1:0]  m_op;
  logic [15:0] m_d;
  logic [15:0] m_acc = 16'h0;
  bit          m_c = 0;
  bit          m_o = 0;

  // Values captured by get_result for the directed checks.
  logic [15:0] r_acc;
  logic        r_c, r_o, r_z;

  my_acc_16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .D(d),
    .out_valid(out_valid), .out_ready(out_ready),
    .ACC(acc), .carry(carry), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic over the command rules.
  task automatic model_exec();
    int sa, sd, s;
    bit of;
    logic [16:0] full;
    logic [15:0] wrapped;
    sa = $signed(m_acc);
    sd = $signed(m_d);
    s = 0;
    of = 0;
    wrapped = m_acc;
    case (m_op)
      2'b00: begin m_acc = m_d; m_c = 0; m_o = 0; end
      2'b11: begin m_acc = 16'h0; m_c = 0; m_o = 0; end
      default: begin
        if (m_op == 2'b01) begin
          full = {1'b0, m_acc} + {1'b0, m_d};
          m_c = full[16];
          wrapped = full[15:0];
          s = sa + sd;
        end else begin
          m_c = (m_acc < m_d);
          wrapped = m_acc - m_d;
          s = sa - sd;
        end
        of = (s > 32767) || (s < -32768);
        m_o = m_o | of;
        m_acc = wrapped;
`ifdef MY_ACC_SATURATE_EN
        if (of) m_acc = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
    endcase
  endtask

  // Single compare process: advance the model at each rising edge, check the DUT on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_stage = 0; m_acc = 16'h0; m_c = 0; m_o = 0;
      end else if (m_busy && m_stage == 1) begin
        model_exec();
        m_stage = 2;
      end else if (m_busy && m_stage == 2) begin
        if (out_ready) begin m_busy = 0; m_stage = 0; end
      end else if (!m_busy && in_valid) begin
        m_op = op; m_d = d; m_busy = 1; m_stage = 1;
      end
      @(negedge clk);
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, (m_busy && m_stage == 2));
      chk("acc", acc, m_acc);
      chk("carry", carry, m_c);
      chk("ovf", ovf, m_o);
      chk("zero", zero, (m_acc == 16'h0));
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [15:0] v);
    bit rdy;
    int n;
    n = 0;
    in_valid = 1'b1; op = o; d = v;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 50);
    in_valid = 1'b0;
    if (!rdy) begin
      fails++; tests++;
      $display("FAIL send_timeout: in_ready never 1 within %0d cycles", n);
    end
  endtask

  task automatic get_result();
    int n;
    n = 0;
    out_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
    if (!out_valid) begin
      fails++; tests++;
      $display("FAIL result_timeout: out_valid never 1 within %0d cycles", n);
    end
    r_acc = acc; r_c = carry; r_o = ovf; r_z = zero;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] o, input logic [15:0] v);
    send(o, v);
    get_result();
  endtask

  initial begin
    logic [15:0] sat_or;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_acc", acc, 16'h0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    run(2'b00, 16'd1); run(2'b10, 16'd0);
    chk("t1_acc", r_acc, 16'h1); chk("t1_zero", r_z, 1'b0);

    run(2'b00, 16'd2); run(2'b10, 16'd1);
    chk("t2a_acc", r_acc, 16'h1); chk("t2a_carry", r_c, 1'b0);
    run(2'b00, 16'd1); run(2'b10, 16'd2);
    chk("t2b_acc", r_acc, 16'hFFFF); chk("t2b_carry", r_c, 1'b1); chk("t2b_ovf", r_o, 1'b0);

`ifdef MY_ACC_SATURATE_EN
    sat_or = 16'h7FFF;
`else
    sat_or = 16'h8000;
`endif
    run(2'b00, 16'h7FFF); run(2'b01, 16'h0001);
    chk("t3_acc", r_acc, sat_or); chk("t3_ovf", r_o, 1'b1);
    run(2'b01, 16'h0000);
    chk("t3_sticky", r_o, 1'b1);
    run(2'b11, 16'h1234);
    chk("t3_clr_ovf", r_o, 1'b0); chk("t3_clr_acc", r_acc, 16'h0);

`ifdef MY_ACC_SATURATE_EN
    sat_or = 16'h7FFF;
`else
    sat_or = 16'hFFFF;
`endif
    run(2'b00, 16'd32767); run(2'b10, 16'd32768);
    chk("t4a_acc", r_acc, sat_or); chk("t4a_ovf", r_o, 1'b1); chk("t4a_carry", r_c, 1'b1);
    run(2'b00, 16'd1024); run(2'b10, 16'd1023);
    chk("t4b_acc", r_acc, 16'h1); chk("t4b_ovf", r_o, 1'b0);

    // Stall in DONE with a competing command on the input.
    out_ready = 1'b0;
    send(2'b00, 16'd5);
    @(posedge clk); #1;
    in_valid = 1'b1; op = 2'b01; d = 16'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_out_valid", out_valid, 1'b1);
      chk("t5_in_ready", in_ready, 1'b0);
      chk("t5_acc", acc, 16'd5);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_capture", acc, 16'd5);

    // Reset lands while ADD 5 is executing.
    run(2'b00, 16'd10);
    send(2'b01, 16'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_acc", acc, 16'h0);
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Random traffic, boundary-biased operands, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: d = 16'h7FFF;
        1: d = 16'h8000;
        2: d = 16'hFFFF;
        3: d = 16'h0000;
        default: d = 16'($urandom());
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
